// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised architectural register file for the MCU core.
//            It has NUM_RD combinational read ports and one byte-strobed write
//            port. Register 0 can be hardwired to zero, and a same-cycle write
//            can be forwarded to the read ports (bypass). A clear-sweep engine
//            zeroes the file one register per cycle without needing a reset.
// Ports    : clk, rst_n        - clock, synchronous active-low reset
//            wr_en/addr/data   - write request, index and data
//            wr_strb           - byte enables (bit k -> bits [8k+7:8k])
//            rd_addr/rd_data   - packed read indices and read data
//            clr_req           - pulse that starts a clear sweep
//            clr_busy          - high while the sweep runs
//            wr_drop           - one-cycle pulse for a write dropped by a sweep
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic [XLEN/8-1:0]      wr_strb,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic                   wr_drop
);

    localparam int            c_NB       = XLEN / 8;
    localparam bit            c_ZERO     = (ZERO_REG != 0);
    localparam bit            c_BYP      = (BYPASS != 0);
    localparam logic [AW-1:0] c_LAST     = AW'(NUM_REGS - 1);
    // Register 0 never needs clearing when it is hardwired to zero.
    localparam logic [AW-1:0] c_FIRST    = AW'(c_ZERO ? 1 : 0);

    localparam logic [0:0]    c_ST_IDLE  = 1'b0;
    localparam logic [0:0]    c_ST_SWEEP = 1'b1;

    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   w_idx_nxt;
    logic            r_drop;
    logic            w_idle;
    logic            w_wr_ok;
    logic [XLEN-1:0] w_wr_merged;

    assign w_idle   = (r_state == c_ST_IDLE);
    // A write commits only in IDLE and never to a hardwired-zero register 0.
    assign w_wr_ok  = wr_en && w_idle && !(c_ZERO && (wr_addr == '0));
    assign clr_busy = (r_state == c_ST_SWEEP);
    assign wr_drop  = r_drop;

    // Value the write target will hold after the edge: strobed bytes from
    // wr_data, the rest from the current contents. Shared by the write path
    // and the bypass path.
    always_comb begin
        w_wr_merged = r_regs[wr_addr];
        for (int k = 0; k < c_NB; k++) begin
            if (wr_strb[k]) begin
                w_wr_merged[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
    end

    // Clear-sweep next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            c_ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = c_ST_SWEEP;
                    w_idx_nxt   = c_FIRST;
                end
            end
            c_ST_SWEEP: begin
                // Explicit terminal compare; the index is forced back to 0
                // instead of relying on the increment wrapping.
                if (r_idx == c_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt   = r_idx + AW'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_drop  <= wr_en && !w_idle;
            if (!w_idle) begin
                r_regs[r_idx] <= '0;
            end else if (w_wr_ok) begin
                r_regs[wr_addr] <= w_wr_merged;
            end
        end
    end

    // Read ports.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;

        assign w_ra = rd_addr[p*AW +: AW];

        always_comb begin
            w_rd = r_regs[w_ra];
            // w_wr_ok already excludes SWEEP and the zero register.
            if (c_BYP && w_wr_ok && (wr_addr == w_ra)) begin
                w_rd = w_wr_merged;
            end
            if (c_ZERO && (w_ra == '0)) begin
                w_rd = '0;
            end
        end

        assign rd_data[p*XLEN +: XLEN] = w_rd;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised, synchronous successor to the 16x32 core register file; it holds the CPU architectural registers.
- Provides NUM_RD combinational read ports, one byte-strobed write port, an optional hardwired-zero register 0 and optional write-to-read bypass.
- Adds a hardware clear-sweep engine, so firmware or the debug path can zero the file without a full reset.
- Sits between the decode and execute stages of the MCU core.

Parameters:
- XLEN, 32, register width in bits; must be a multiple of 8.
- NUM_REGS, 16, register count; power of two, >= 2.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.
- AW, $clog2(NUM_REGS), address width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  write request.
- wr_addr  in  AW  write register index.
- wr_data  in  XLEN  write data.
- wr_strb  in  XLEN/8  byte enables; bit k covers bits [8k+7:8k].
- rd_addr  in  NUM_RD*AW  packed read indices; port p = bits [p*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data; port p = bits [p*XLEN +: XLEN].
- clr_req  in  1  single-cycle pulse requesting a clear sweep.
- clr_busy  out  1  high while the sweep runs.
- wr_drop  out  1  registered pulse: a write was rejected because the sweep was running.

Behaviour:
- Reset: rst_n low at a clk edge zeroes every register, returns the FSM to IDLE, and sets clr_busy=0, wr_drop=0 and the sweep index to 0. Reset beats every other input, including mid-sweep.
- Write, IDLE state:
  - wr_en=1 updates register wr_addr at the edge.
  - Only the bytes with wr_strb bit set change; the other bytes keep their value.
  - wr_strb=0 with wr_en=1 is a legal no-op.
- ZERO_REG=1: writes to index 0 are discarded and register 0 reads 0 on every port.
- ZERO_REG=0: register 0 is an ordinary register.
- Reads: combinational, zero-latency. rd_data[p] = contents of register rd_addr[p]. Any number of ports may address the same register.
- Bypass (BYPASS=1), per read port p: when all of the following hold, rd_data[p] returns the merged value (strobed bytes from wr_data, other bytes from current contents) in the same cycle:
  - wr_en=1;
  - wr_addr==rd_addr[p];
  - FSM is IDLE;
  - the address is not the zero register (when ZERO_REG=1).
- BYPASS=0: reads return pre-write contents; new data is visible the cycle after the edge.
- Clear FSM, two states:
  - IDLE -> SWEEP when clr_req=1. The sweep index loads with 1 if ZERO_REG=1, else 0. clr_busy goes high the next cycle.
  - SWEEP: each cycle zeroes register[index] and increments index. At index==NUM_REGS-1 that register is zeroed and the FSM returns to IDLE; clr_busy falls the following cycle.
  - Sweep duration is NUM_REGS-1 cycles (ZERO_REG=1) or NUM_REGS cycles (ZERO_REG=0).
  - clr_req while in SWEEP is ignored; the sweep does not restart.
- Writes during SWEEP: dropped with no state change; wr_drop=1 on the next cycle for one cycle per dropped write.
- Reads during SWEEP: return current, partially cleared contents. No bypass.
- clr_req and wr_en in the same IDLE cycle: the write commits at that edge and the sweep starts from the next cycle, so the written register is later zeroed. wr_drop stays 0.
- Index arithmetic: the index is AW bits wide. The terminal compare must not depend on wrap-around; index wraps to 0 on exit.
- No X propagation: every register is defined after the first reset edge.

Test Plan:
- Reset and ZERO_REG: write 0xDEADBEEF to r5, hold rst_n=0 one edge -> r5 reads 0. Write 0x12345678 to r0 -> r0 reads 0 on both ports.
- Byte strobe: r3=0xAABBCCDD, then write 0x11223344 with wr_strb=4'b0101 -> r3=0xAA22CC44.
- Bypass: with BYPASS=1, write r7=0xCAFEF00D while rd_addr port0=7 -> rd_data0=0xCAFEF00D in the same cycle; port1=7 with BYPASS=0 instance -> old value that cycle, new value next cycle.
- Clear sweep: fill r1..r15 with their index. Pulse clr_req -> clr_busy high for 15 cycles; register k reads 0 from cycle k onward; all read 0 after clr_busy falls.
- Write during sweep: wr_en to r15 at sweep cycle 3 with 0x55 -> wr_drop=1 next cycle, r15 ends at 0; second clr_req mid-sweep -> no extension of clr_busy.
- Reset mid-sweep and width generalisation: assert rst_n=0 at sweep cycle 5 -> next cycle clr_busy=0 and all registers 0. Rerun the scenarios with XLEN=64, NUM_REGS=32, NUM_RD=3 -> same results.
